// File: rtl/fifo_drain_arb_pkg.sv
// fifo_drain_arb_pkg
//   Shared sizing for the FIFO drain arbiter. The source/destination FIFOs
//   use the same word width, so both sides import these values.
package fifo_drain_arb_pkg;

   localparam int ARB_DATA_W = 6;   // FIFO word width
   localparam int ARB_N_SRC  = 4;   // number of source FIFOs
   localparam int ARB_CNT_W  = 8;   // width of the written-word counter

endpackage

// File: rtl/fifo_drain_arb_rr_pick.sv
// fifo_drain_arb_rr_pick
//   Combinational rotate-priority encoder. The search starts one past the
//   previous grant and wraps, so every requester is served in turn.
// Ports:
//   req        in   N_SRC   request vector (1 = source has data)
//   last_grant in   SEL_W   index of the most recent grant
//   grant      out  N_SRC   one-hot grant (all zero when no request)
//   grant_idx  out  SEL_W   index of the granted source
//   any_req    out  1       at least one request present
module fifo_drain_arb_rr_pick #(
   parameter int N_SRC = 4,
   parameter int SEL_W = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] last_grant,
   output logic [N_SRC-1:0] grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             any_req
);

   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      j         = 0;
      // k = N_SRC wraps back to last_grant itself, so a lone requester
      // can be granted again on consecutive cycles.
      for (int k = 1; k <= N_SRC; k++) begin
         j = (int'(last_grant) + k) % N_SRC;
         if (!any_req && req[j]) begin
            any_req   = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = j[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_drain_arb.sv
// fifo_drain_arb
//   Drains up to N_SRC source FIFOs round-robin and merges their words into
//   one destination FIFO. Three stages: issue (registered pop), return
//   (expect valid one cycle after the pop), write (registered dst write).
// Ports:
//   clk, RESET        clock, synchronous active-high reset
//   src_empty [N]     look-ahead empty flag of each source
//   src_valid [N]     read-return valid of each source
//   src_data  [N*W]   read-return data, source i at [i*W +: W]
//   src_rd    [N]     registered one-hot pop strobe
//   dst_pause         destination almost-full
//   dst_full          destination full
//   dst_wr, dst_data  registered destination write
//   err_arb           one-cycle pulse on a read-return protocol error
//   word_cnt          words written to the destination, wraps
module fifo_drain_arb
   import fifo_drain_arb_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W,
   parameter int N_SRC  = ARB_N_SRC
) (
   input  logic                    clk,
   input  logic                    RESET,
   input  logic [N_SRC-1:0]        src_empty,
   input  logic [N_SRC-1:0]        src_valid,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   output logic [N_SRC-1:0]        src_rd,
   input  logic                    dst_pause,
   input  logic                    dst_full,
   output logic                    dst_wr,
   output logic [DATA_W-1:0]       dst_data,
   output logic                    err_arb,
   output logic [ARB_CNT_W-1:0]    word_cnt
);

   localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0]  grant;
   logic [SEL_W-1:0]  grant_idx;
   logic [SEL_W-1:0]  last_grant;
   logic              any_req;
   logic              issue;

   // vld_pipe[0]: a pop is on src_rd this cycle
   // vld_pipe[1]: a return is expected this cycle (ret_sel is live)
   logic [1:0]        vld_pipe;
   logic [N_SRC-1:0]  ret_sel;
   // Source popped on the reset edge; its valid lands after reset and is
   // dropped silently instead of being flagged as unexpected.
   logic [N_SRC-1:0]  flush_sel;

   logic [N_SRC-1:0]  hit;
   logic              wr_next;
   logic              err_next;
   logic [DATA_W-1:0] ret_data;

   fifo_drain_arb_rr_pick #(
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req        (~src_empty),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   // src_empty only reaches src_rd through the flop below; the FIFO's
   // empty flag already depends combinationally on its own fifo_rd.
   assign issue = any_req & ~dst_pause & ~dst_full;

   assign hit      = src_valid & ret_sel;
   assign wr_next  = |hit;
   assign err_next = (vld_pipe[1] & ~wr_next)
                   | (|(src_valid & ~ret_sel & ~flush_sel));

   always_comb begin
      ret_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (ret_sel[i]) ret_data = src_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         src_rd     <= '0;
         last_grant <= SEL_W'(N_SRC - 1);
         vld_pipe   <= '0;
         ret_sel    <= '0;
         flush_sel  <= src_rd;
         dst_wr     <= 1'b0;
         dst_data   <= '0;
         err_arb    <= 1'b0;
         word_cnt   <= '0;
      end else begin
         src_rd    <= issue ? grant : '0;
         if (issue) last_grant <= grant_idx;
         vld_pipe  <= {vld_pipe[0], issue};
         ret_sel   <= src_rd;
         flush_sel <= '0;
         // dst_full does not gate the write: a word already returned is
         // written anyway and the destination reports its own overflow.
         dst_wr    <= wr_next;
         if (wr_next) dst_data <= ret_data;
         err_arb   <= err_next;
         word_cnt  <= word_cnt + ARB_CNT_W'(wr_next);
      end
   end

endmodule

// File: tb/tb_fifo_drain_arb.sv
// tb_fifo_drain_arb
//   Source FIFOs are modelled as arrays with push/pop counters (look-ahead
//   empty, one-cycle read latency). Every popped word with a valid return is
//   queued as an expected destination write and checked in order.
module tb_fifo_drain_arb;

   localparam int DW = 6;
   localparam int NS = 4;

   logic            clk = 1'b0;
   logic            RESET;
   logic [NS-1:0]   src_empty;
   logic [NS-1:0]   src_valid;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]   src_rd;
   logic            dst_pause;
   logic            dst_full;
   logic            dst_wr;
   logic [DW-1:0]   dst_data;
   logic            err_arb;
   logic [7:0]      word_cnt;

   fifo_drain_arb dut (
      .clk       (clk),
      .RESET     (RESET),
      .src_empty (src_empty),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_rd    (src_rd),
      .dst_pause (dst_pause),
      .dst_full  (dst_full),
      .dst_wr    (dst_wr),
      .dst_data  (dst_data),
      .err_arb   (err_arb),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---- source FIFO model ----
   logic [DW-1:0] mem [NS][1024];
   int            pushed  [NS] = '{default: 0};
   int            popped  [NS] = '{default: 0};
   int            drop_at [NS] = '{default: -1};
   logic [DW-1:0] mdl_data [NS];
   logic [NS-1:0] mdl_valid = '0;
   logic [NS-1:0] inj = '0;
   logic          started = 1'b0;
   logic [DW-1:0] exp_q [$];

   always_comb begin
      src_empty = '1;
      for (int i = 0; i < NS; i++)
         src_empty[i] = (pushed[i] - popped[i] - (src_rd[i] ? 1 : 0)) <= 0;
   end

   always_comb begin
      src_data = '0;
      for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = mdl_data[i];
   end

   assign src_valid = mdl_valid | inj;

   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         mdl_valid[i] <= 1'b0;
         if (started && src_rd[i]) begin
            mdl_data[i]  <= mem[i][popped[i]];
            mdl_valid[i] <= (popped[i] != drop_at[i]);
            if (!RESET && popped[i] != drop_at[i]) exp_q.push_back(mem[i][popped[i]]);
            popped[i]    <= popped[i] + 1;
         end
      end
      if (RESET) exp_q.delete();
   end

   // ---- destination monitor ----
   int wr_seen  = 0;
   int err_seen = 0;

   always @(negedge clk) begin
      if (dst_wr) begin
         wr_seen <= wr_seen + 1;
         if (exp_q.size() == 0) chk("sb_depth", exp_q.size(), 1);
         else chk("dst_data", int'(dst_data), int'(exp_q.pop_front()));
      end
      if (err_arb) err_seen <= err_seen + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic [DW-1:0] w);
      mem[s][pushed[s]] = w;
      pushed[s] = pushed[s] + 1;
   endtask

   logic [NS-1:0] seq_a [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
   int exp_total = 0;
   int e0;
   int k;

   initial begin
      RESET = 1'b1; dst_pause = 1'b0; dst_full = 1'b0;
      repeat (3) tick();
      chk("rst_src_rd",   int'(src_rd),   0);
      chk("rst_dst_wr",   int'(dst_wr),   0);
      chk("rst_dst_data", int'(dst_data), 0);
      chk("rst_err",      int'(err_arb),  0);
      chk("rst_cnt",      int'(word_cnt), 0);
      started = 1'b1; RESET = 1'b0;
      tick();

      // all four sources, two words each
      for (int s = 0; s < NS; s++)
         for (int j = 0; j < 2; j++) push(s, DW'($urandom_range(0, 63)));
      exp_total += 8;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c <= 8) chk("rr_seq", int'(src_rd), int'(seq_a[c-1]));
         else        chk("rr_idle", int'(src_rd), 0);
         if (c >= 3 && c <= 10) chk("stream_wr", int'(dst_wr), 1);
      end
      tick();
      chk("cnt_a", int'(word_cnt), exp_total);

      // only source 2, three words
      push(2, 6'h11); push(2, 6'h22); push(2, 6'h33);
      exp_total += 3;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk("s2_rd", int'(src_rd), (c <= 3) ? 4 : 0);
         chk("s2_wr", int'(dst_wr), (c >= 3 && c <= 5) ? 1 : 0);
         if (c >= 3 && c <= 5) chk("s2_data", int'(dst_data), 'h11 * (c - 2));
      end
      tick();
      chk("cnt_b", int'(word_cnt), exp_total);

      // pause while streaming from sources 0 and 1
      for (int j = 0; j < 10; j++) begin
         push(0, DW'($urandom_range(0, 63)));
         push(1, DW'($urandom_range(0, 63)));
      end
      exp_total += 20;
      tick(); chk("pre_rd0", int'(src_rd), 1);
      tick(); chk("pre_rd1", int'(src_rd), 2);
      tick(); chk("pre_rd2", int'(src_rd), 1);
      dst_pause = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk("pause_wr", int'(dst_wr), (c <= 2) ? 1 : 0);
         chk("pause_rd", int'(src_rd), 0);
      end
      dst_pause = 1'b0;
      tick(); chk("resume_rd", int'(src_rd), 2);
      dst_full = 1'b1;
      tick(); chk("full_rd", int'(src_rd), 0);
      tick(); chk("full_wr", int'(dst_wr), 1);
      dst_full = 1'b0;
      repeat (40) tick();
      chk("cnt_c", int'(word_cnt), exp_total);
      chk("sb_drain_c", exp_q.size(), 0);

      // missing valid after a pop of source 1, then a stray valid
      e0 = err_seen;
      drop_at[1] = pushed[1];
      push(1, 6'h2a);
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) chk("drop_rd", int'(src_rd), 2);
         chk("drop_err", int'(err_arb), (c == 3) ? 1 : 0);
         chk("drop_wr", int'(dst_wr), 0);
      end
      chk("cnt_drop", int'(word_cnt), exp_total);
      inj = 4'b1000;
      tick(); chk("inj_err", int'(err_arb), 1);
      inj = '0;
      tick(); chk("inj_err_clr", int'(err_arb), 0);
      chk("inj_wr", int'(dst_wr), 0);
      tick(); chk("err_pulses", err_seen - e0, 2);
      chk("cnt_inj", int'(word_cnt), exp_total);

      // reset while streaming from sources 1 and 2
      for (int j = 0; j < 20; j++) begin
         push(1, DW'($urandom_range(0, 63)));
         push(2, DW'($urandom_range(0, 63)));
      end
      repeat (5) tick();
      RESET = 1'b1;
      push(0, 6'h05); push(0, 6'h06);
      tick();
      chk("mid_rst_rd",   int'(src_rd),   0);
      chk("mid_rst_wr",   int'(dst_wr),   0);
      chk("mid_rst_data", int'(dst_data), 0);
      chk("mid_rst_err",  int'(err_arb),  0);
      chk("mid_rst_cnt",  int'(word_cnt), 0);
      exp_total = 0;
      for (int s = 0; s < NS; s++) exp_total += pushed[s] - popped[s];
      e0 = err_seen;
      RESET = 1'b0;
      tick(); chk("post_rst_grant", int'(src_rd), 1);
      repeat (60) tick();
      chk("cnt_e", int'(word_cnt), exp_total);
      chk("sb_drain_e", exp_q.size(), 0);
      chk("rst_no_err", err_seen - e0, 0);

      // 256 writes from source 3: counter wraps on the last one
      RESET = 1'b1; tick(); RESET = 1'b0; tick();
      for (int j = 0; j < 256; j++) push(3, DW'(j));
      k = 0;
      for (int c = 0; c < 400 && k < 256; c++) begin
         tick();
         if (dst_wr) begin
            k++;
            if (k == 1)   chk("cnt_first", int'(word_cnt), 1);
            if (k == 255) chk("cnt_255",   int'(word_cnt), 255);
            if (k == 256) chk("cnt_wrap",  int'(word_cnt), 0);
         end
      end
      chk("wrap_writes", k, 256);
      repeat (4) tick();
      chk("sb_drain_f", exp_q.size(), 0);
      chk("cnt_f", int'(word_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
